// File: rtl/jtframe_romrq_arb_if.sv
// Bundle of the slot-side ROM request bus and the SDRAM read port seen by jtframe_romrq_arb.
// master = game core plus SDRAM controller side, slave = the arbiter.
interface jtframe_romrq_arb_if #(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned AW    = 22
);
    logic                downloading;
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*32-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic [31:0]         data_read;
    logic                data_rdy;
    logic                busy;

    modport master (
        output downloading, slot_req, slot_addr, sdram_ack, data_read, data_rdy,
        input  slot_ok, slot_dout, sdram_req, sdram_addr, busy
    );

    modport slave (
        input  downloading, slot_req, slot_addr, sdram_ack, data_read, data_rdy,
        output slot_ok, slot_dout, sdram_req, sdram_addr, busy
    );
endinterface

// File: rtl/jtframe_romrq_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM requesters,
// each fronted by a one-longword cache so repeated reads skip the SDRAM.
module jtframe_romrq_arb #(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned AW    = 22
) (
    input logic                clk_rom,
    input logic                rst_n,
    jtframe_romrq_arb_if.slave bus
);
    localparam int unsigned GW = $clog2(SLOTS);

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitRdy} state_t;

    state_t           state;
    logic [GW-1:0]    rr_ptr;
    logic [GW-1:0]    gnt;
    logic [GW-1:0]    gnt_next;
    logic [SLOTS-1:0] valid;
    logic [AW-2:0]    tag  [SLOTS];
    logic [31:0]      dout [SLOTS];
    logic             sdram_req;
    logic [AW-1:0]    sdram_addr;

    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] pend;
    logic             pick_found;
    logic [GW-1:0]    pick_idx;
    logic [AW-2:0]    pick_tag;
    logic             fill;

    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            hit[i] = valid[i] && (tag[i] == bus.slot_addr[i*AW+1 +: AW-1]);
        end
    end

    assign pend         = bus.slot_req & ~hit;
    assign bus.slot_ok  = bus.slot_req & hit;
    assign bus.sdram_req  = sdram_req;
    assign bus.sdram_addr = sdram_addr;
    assign bus.busy       = (state != StIdle);

    for (genvar g = 0; g < int'(SLOTS); g++) begin : g_dout
        assign bus.slot_dout[g*32 +: 32] = dout[g];
    end

    // Scan downwards so the last match written is the closest one at or after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_tag   = '0;
        for (int k = int'(SLOTS) - 1; k >= 0; k--) begin
            automatic int unsigned s = (32'(rr_ptr) + 32'(k)) % SLOTS;
            if (pend[s]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(s);
                pick_tag   = bus.slot_addr[s*AW+1 +: AW-1];
            end
        end
    end

    assign gnt_next = (gnt == GW'(SLOTS - 1)) ? '0 : gnt + 1'b1;
    assign fill     = ((state == StWaitAck) && bus.sdram_ack && bus.data_rdy) ||
                      ((state == StWaitRdy) && bus.data_rdy);

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            rr_ptr     <= '0;
            gnt        <= '0;
            valid      <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            for (int i = 0; i < int'(SLOTS); i++) begin
                tag[i]  <= '0;
                dout[i] <= '0;
            end
        end else begin
            if (bus.downloading) valid <= '0;
            unique case (state)
                StIdle: begin
                    if (!bus.downloading && pick_found) begin
                        gnt        <= pick_idx;
                        sdram_addr <= {pick_tag, 1'b0};
                        sdram_req  <= 1'b1;
                        state      <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (bus.sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= bus.data_rdy ? StIdle : StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    if (bus.data_rdy) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
            // The tag comes from the fetched address, never the slot's current one.
            if (fill) begin
                dout[gnt]  <= bus.data_read;
                tag[gnt]   <= sdram_addr[AW-1:1];
                valid[gnt] <= ~bus.downloading;
                rr_ptr     <= gnt_next;
            end
        end
    end
endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Directed bench for jtframe_romrq_arb: cache hit/miss, round-robin order,
// same-cycle ack/rdy, download flush and asynchronous reset.
module tb_jtframe_romrq_arb;
    localparam int unsigned SLOTS = 4;
    localparam int unsigned AW    = 22;

    logic clk_rom = 1'b0;
    logic rst_n   = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    always #5 clk_rom = ~clk_rom;

    jtframe_romrq_arb_if #(.SLOTS(SLOTS), .AW(AW)) bus ();

    jtframe_romrq_arb #(.SLOTS(SLOTS), .AW(AW)) dut (
        .clk_rom (clk_rom),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    task automatic clear_inputs();
        bus.downloading = 1'b0;
        bus.slot_req    = '0;
        bus.slot_addr   = '0;
        bus.sdram_ack   = 1'b0;
        bus.data_read   = '0;
        bus.data_rdy    = 1'b0;
    endtask

    task automatic set_addr(input int s, input logic [AW-1:0] a);
        bus.slot_addr[s*AW +: AW] = a;
    endtask

    task automatic do_reset();
        @(negedge clk_rom);
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_rom);
        rst_n = 1'b1;
    endtask

    // Waits for a grant, checks its address, then runs a split ack / rdy handshake.
    task automatic serve_one(input int s, input logic [AW-1:0] exp_addr, input logic [31:0] data);
        int waited = 0;
        while (bus.sdram_req !== 1'b1 && waited < 8) begin
            @(negedge clk_rom);
            #1;
            waited++;
        end
        n_cmp++;
        if (bus.sdram_req !== 1'b1) begin
            n_bad++;
            $display("FAIL grant_wait_slot%0d: sdram_req=%b required 1", s, bus.sdram_req);
        end
        n_cmp++;
        if (bus.sdram_addr !== exp_addr) begin
            n_bad++;
            $display("FAIL grant_addr_slot%0d: sdram_addr=%h required %h", s, bus.sdram_addr,
                     exp_addr);
        end
        bus.sdram_ack = 1'b1;
        @(negedge clk_rom);
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = data;
        @(negedge clk_rom);
        bus.data_rdy  = 1'b0;
        #1;
        n_cmp++;
        if (bus.slot_dout[s*32 +: 32] !== data) begin
            n_bad++;
            $display("FAIL fill_dout_slot%0d: dout=%h required %h", s, bus.slot_dout[s*32 +: 32],
                     data);
        end
        n_cmp++;
        if (bus.slot_ok[s] !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_ok_slot%0d: slot_ok=%b required 1", s, bus.slot_ok[s]);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk_rom);
        #1;
        n_cmp++;
        if (bus.sdram_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_req: sdram_req=%b required 0", bus.sdram_req);
        end
        n_cmp++;
        if (bus.sdram_addr !== '0) begin
            n_bad++; $display("FAIL reset_addr: sdram_addr=%h required 0", bus.sdram_addr);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: busy=%b required 0", bus.busy);
        end
        n_cmp++;
        if (bus.slot_ok !== 4'b0000 || bus.slot_dout !== '0) begin
            n_bad++;
            $display("FAIL reset_slots: slot_ok=%b dout=%h required 0/0", bus.slot_ok,
                     bus.slot_dout);
        end
        @(negedge clk_rom);
        rst_n = 1'b1;
    endtask

    task automatic test_miss_fill();
        @(negedge clk_rom);
        set_addr(0, 22'h000100);
        bus.slot_req = 4'b0001;
        #1;
        n_cmp++;
        if (bus.slot_ok[0] !== 1'b0) begin
            n_bad++; $display("FAIL miss_no_ok: slot_ok0=%b required 0", bus.slot_ok[0]);
        end
        @(negedge clk_rom);
        n_cmp++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h000100) begin
            n_bad++;
            $display("FAIL miss_grant: req=%b addr=%h required 1/000100", bus.sdram_req,
                     bus.sdram_addr);
        end
        repeat (2) @(negedge clk_rom);
        n_cmp++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h000100) begin
            n_bad++;
            $display("FAIL miss_hold: req=%b addr=%h required 1/000100", bus.sdram_req,
                     bus.sdram_addr);
        end
        bus.sdram_ack = 1'b1;
        @(negedge clk_rom);
        bus.sdram_ack = 1'b0;
        n_cmp++;
        if (bus.sdram_req !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL miss_after_ack: req=%b busy=%b required 0/1", bus.sdram_req, bus.busy);
        end
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'hCAFEBABE;
        #1;
        n_cmp++;
        if (bus.slot_ok[0] !== 1'b0) begin
            n_bad++; $display("FAIL miss_ok_early: slot_ok0=%b required 0", bus.slot_ok[0]);
        end
        @(negedge clk_rom);
        bus.data_rdy = 1'b0;
        #1;
        n_cmp++;
        if (bus.slot_ok[0] !== 1'b1 || bus.slot_dout[31:0] !== 32'hCAFEBABE) begin
            n_bad++;
            $display("FAIL miss_fill: ok=%b dout=%h required 1/cafebabe", bus.slot_ok[0],
                     bus.slot_dout[31:0]);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL miss_idle: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_hit();
        @(negedge clk_rom);
        set_addr(0, 22'h000101);
        #1;
        n_cmp++;
        if (bus.slot_ok[0] !== 1'b1) begin
            n_bad++; $display("FAIL hit_same_cycle: slot_ok0=%b required 1", bus.slot_ok[0]);
        end
        @(negedge clk_rom);
        #1;
        n_cmp++;
        if (bus.sdram_req !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_no_access: req=%b busy=%b required 0/0", bus.sdram_req, bus.busy);
        end
        // Stray handshake pulses while idle must be ignored.
        bus.sdram_ack = 1'b1;
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'hDEADBEEF;
        @(negedge clk_rom);
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.slot_dout[31:0] !== 32'hCAFEBABE || bus.slot_ok[0] !== 1'b1)
        begin
            n_bad++;
            $display("FAIL stray_pulse: busy=%b dout=%h ok=%b required 0/cafebabe/1", bus.busy,
                     bus.slot_dout[31:0], bus.slot_ok[0]);
        end
        bus.slot_req = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        @(negedge clk_rom);
        set_addr(0, 22'h001000);
        set_addr(1, 22'h002001);
        set_addr(2, 22'h003000);
        set_addr(3, 22'h004000);
        bus.slot_req = 4'b1111;
        serve_one(0, 22'h001000, 32'hA0A00000);
        @(negedge clk_rom);
        #1;
        n_cmp++;
        if (bus.slot_ok[0] !== 1'b1 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_cached_while_busy: ok0=%b busy=%b required 1/1", bus.slot_ok[0],
                     bus.busy);
        end
        serve_one(1, 22'h002000, 32'hA1A11111);
        serve_one(2, 22'h003000, 32'hA2A22222);
        set_addr(2, 22'h003010);
        #1;
        n_cmp++;
        if (bus.slot_ok[2] !== 1'b0) begin
            n_bad++; $display("FAIL rr_addr_change: ok2=%b required 0", bus.slot_ok[2]);
        end
        serve_one(3, 22'h004000, 32'hA3A33333);
        serve_one(2, 22'h003010, 32'hB2B22222);
        n_cmp++;
        if (bus.slot_ok !== 4'b1111) begin
            n_bad++; $display("FAIL rr_all_cached: slot_ok=%b required 1111", bus.slot_ok);
        end
        @(negedge clk_rom);
        bus.slot_req = '0;
    endtask

    task automatic test_ack_rdy_same();
        int waited = 0;
        @(negedge clk_rom);
        set_addr(1, 22'h005000);
        set_addr(3, 22'h006000);
        bus.slot_req = 4'b1010;
        while (bus.sdram_req !== 1'b1 && waited < 8) begin
            @(negedge clk_rom);
            #1;
            waited++;
        end
        n_cmp++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h006000) begin
            n_bad++;
            $display("FAIL same_first_grant: req=%b addr=%h required 1/006000", bus.sdram_req,
                     bus.sdram_addr);
        end
        bus.sdram_ack = 1'b1;
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h11112222;
        @(negedge clk_rom);
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.sdram_req !== 1'b0) begin
            n_bad++;
            $display("FAIL same_idle: busy=%b req=%b required 0/0", bus.busy, bus.sdram_req);
        end
        n_cmp++;
        if (bus.slot_ok[3] !== 1'b1 || bus.slot_dout[127:96] !== 32'h11112222) begin
            n_bad++;
            $display("FAIL same_fill: ok3=%b dout3=%h required 1/11112222", bus.slot_ok[3],
                     bus.slot_dout[127:96]);
        end
        @(negedge clk_rom);
        #1;
        n_cmp++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h005000) begin
            n_bad++;
            $display("FAIL same_next_grant: req=%b addr=%h required 1/005000", bus.sdram_req,
                     bus.sdram_addr);
        end
        serve_one(1, 22'h005000, 32'h33334444);
        @(negedge clk_rom);
        bus.slot_req = '0;
    endtask

    task automatic test_download();
        int waited = 0;
        @(negedge clk_rom);
        set_addr(2, 22'h007000);
        bus.slot_req = 4'b0100;
        while (bus.sdram_req !== 1'b1 && waited < 8) begin
            @(negedge clk_rom);
            #1;
            waited++;
        end
        n_cmp++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h007000) begin
            n_bad++;
            $display("FAIL dl_grant: req=%b addr=%h required 1/007000", bus.sdram_req,
                     bus.sdram_addr);
        end
        bus.sdram_ack = 1'b1;
        @(negedge clk_rom);
        bus.sdram_ack   = 1'b0;
        bus.downloading = 1'b1;
        @(negedge clk_rom);
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h55556666;
        @(negedge clk_rom);
        bus.data_rdy = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.slot_ok[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL dl_complete: busy=%b ok2=%b required 0/0", bus.busy, bus.slot_ok[2]);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_rom);
            #1;
            n_cmp++;
            if (bus.sdram_req !== 1'b0 || bus.slot_ok !== 4'b0000) begin
                n_bad++;
                $display("FAIL dl_blocked_%0d: req=%b slot_ok=%b required 0/0000", c,
                         bus.sdram_req, bus.slot_ok);
            end
        end
        bus.downloading = 1'b0;
        @(negedge clk_rom);
        #1;
        n_cmp++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h007000) begin
            n_bad++;
            $display("FAIL dl_resume: req=%b addr=%h required 1/007000", bus.sdram_req,
                     bus.sdram_addr);
        end
    endtask

    task automatic test_async_reset();
        serve_one(2, 22'h007000, 32'h77778888);
        @(negedge clk_rom);
        set_addr(1, 22'h008000);
        bus.slot_req = 4'b0110;
        @(negedge clk_rom);
        #1;
        n_cmp++;
        if (bus.sdram_req !== 1'b1 || bus.slot_ok[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL ar_setup: req=%b ok2=%b required 1/1", bus.sdram_req, bus.slot_ok[2]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.sdram_req !== 1'b0 || bus.busy !== 1'b0 || bus.slot_ok !== 4'b0000) begin
            n_bad++;
            $display("FAIL ar_immediate: req=%b busy=%b slot_ok=%b required 0/0/0000",
                     bus.sdram_req, bus.busy, bus.slot_ok);
        end
        @(negedge clk_rom);
        clear_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_miss_fill();
        test_hit();
        test_round_robin();
        test_ack_rdy_same();
        test_download();
        test_async_reset();
        repeat (2) @(negedge clk_rom);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
